// File: rtl/score_counter_if.sv
// Port bundle between the game logic and the score keeper.
// The master side drives the game events; the slave side is the score keeper.
interface score_counter_if #(
    parameter int DIGITS = 4
);
    logic                i_game_tick;
    logic                i_game_start_pulse;
    logic                i_game_over_pulse;
    logic [4*DIGITS-1:0] o_score;
    logic [4*DIGITS-1:0] o_high_score;
    logic                o_milestone_pulse;
    logic [2:0]          o_speed_level;
    logic                o_running;

    modport master (
        output i_game_tick,
        output i_game_start_pulse,
        output i_game_over_pulse,
        input  o_score,
        input  o_high_score,
        input  o_milestone_pulse,
        input  o_speed_level,
        input  o_running
    );

    modport slave (
        input  i_game_tick,
        input  i_game_start_pulse,
        input  i_game_over_pulse,
        output o_score,
        output o_high_score,
        output o_milestone_pulse,
        output o_speed_level,
        output o_running
    );
endinterface

// File: rtl/score_counter.sv
// Packed-BCD game score keeper with high score, 100-point milestones and a
// saturating speed level. All outputs are registered.
module score_counter #(
    parameter int DIGITS          = 4,
    parameter int TICKS_PER_POINT = 6
) (
    input  logic            clk,
    input  logic            rst,
    score_counter_if.slave  bus
);
    localparam int W  = 4 * DIGITS;
    localparam int PW = (TICKS_PER_POINT > 1) ? $clog2(TICKS_PER_POINT) : 1;
    localparam logic [W-1:0]  ALL_NINES = {DIGITS{4'h9}};
    localparam logic [PW-1:0] LAST_TICK = PW'(TICKS_PER_POINT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        OVER    = 2'd2
    } state_t;

    state_t        state;
    logic [PW-1:0] prescaler;
    logic [W-1:0]  score;
    logic [W-1:0]  high_score;
    logic          milestone;
    logic [2:0]    speed_level;
    logic          running;

    logic [W-1:0]  score_inc;
    logic          saturated;
    logic          hit_hundred;

    // Ripple a +1 through the BCD digits; a digit at 9 rolls to 0 and carries.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         carry;
        r     = v;
        carry = 1'b1;
        for (int d = 0; d < DIGITS; d++) begin
            if (carry) begin
                if (v[4*d +: 4] == 4'd9) begin
                    r[4*d +: 4] = 4'd0;
                end else begin
                    r[4*d +: 4] = v[4*d +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign score_inc   = bcd_inc(score);
    assign saturated   = (score == ALL_NINES);
    assign hit_hundred = (score_inc[7:0] == 8'h00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            prescaler   <= '0;
            score       <= '0;
            high_score  <= '0;
            milestone   <= 1'b0;
            speed_level <= 3'd0;
            running     <= 1'b0;
        end else begin
            milestone <= 1'b0;
            case (state)
                IDLE, OVER: begin
                    if (bus.i_game_start_pulse) begin
                        state       <= RUNNING;
                        running     <= 1'b1;
                        score       <= '0;
                        prescaler   <= '0;
                        speed_level <= 3'd0;
                    end
                end
                RUNNING: begin
                    // Game over takes priority over a coincident tick or start.
                    if (bus.i_game_over_pulse) begin
                        state     <= OVER;
                        running   <= 1'b0;
                        prescaler <= '0;
                        if (score > high_score) begin
                            high_score <= score;
                        end
                    end else if (bus.i_game_tick) begin
                        if (prescaler == LAST_TICK) begin
                            prescaler <= '0;
                            if (!saturated) begin
                                score <= score_inc;
                                if (hit_hundred) begin
                                    milestone <= 1'b1;
                                    if (speed_level != 3'd7) begin
                                        speed_level <= speed_level + 3'd1;
                                    end
                                end
                            end
                        end else begin
                            prescaler <= prescaler + PW'(1);
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_score           = score;
    assign bus.o_high_score      = high_score;
    assign bus.o_milestone_pulse = milestone;
    assign bus.o_speed_level     = speed_level;
    assign bus.o_running         = running;
endmodule

// File: tb/tb_score_counter.sv
// Directed bench for score_counter with DIGITS=4, TICKS_PER_POINT=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_score_counter;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    score_counter_if #(.DIGITS(4)) bus ();

    score_counter #(
        .DIGITS          (4),
        .TICKS_PER_POINT (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Hold the tick high for n consecutive sampling edges.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.i_game_tick = 1'b1;
        end
        @(negedge clk);
        bus.i_game_tick = 1'b0;
    endtask

    task automatic pulse(input logic start, input logic over, input logic tick);
        @(negedge clk);
        bus.i_game_start_pulse = start;
        bus.i_game_over_pulse  = over;
        bus.i_game_tick        = tick;
        @(negedge clk);
        bus.i_game_start_pulse = 1'b0;
        bus.i_game_over_pulse  = 1'b0;
        bus.i_game_tick        = 1'b0;
    endtask

    initial begin
        rst                    = 1'b1;
        bus.i_game_tick        = 1'b0;
        bus.i_game_start_pulse = 1'b0;
        bus.i_game_over_pulse  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("reset_score", bus.o_score, 32'h0000);
        check("reset_high", bus.o_high_score, 32'h0000);
        check("reset_running", bus.o_running, 32'd0);
        check("reset_speed", bus.o_speed_level, 32'd0);
        check("reset_milestone", bus.o_milestone_pulse, 32'd0);

        ticks(10);
        check("idle_ticks_score", bus.o_score, 32'h0000);
        check("idle_ticks_running", bus.o_running, 32'd0);

        pulse(1'b1, 1'b0, 1'b0);
        check("start_running", bus.o_running, 32'd1);
        check("start_score", bus.o_score, 32'h0000);
        ticks(7);
        check("seven_ticks", bus.o_score, 32'h0002);
        ticks(1);
        check("eighth_tick_hold", bus.o_score, 32'h0002);
        ticks(1);
        check("ninth_tick", bus.o_score, 32'h0003);

        ticks(288);
        check("score_99", bus.o_score, 32'h0099);
        check("no_milestone_99", bus.o_milestone_pulse, 32'd0);
        ticks(2);
        check("score_99_hold", bus.o_score, 32'h0099);
        ticks(1);
        check("score_100", bus.o_score, 32'h0100);
        check("milestone_100", bus.o_milestone_pulse, 32'd1);
        check("speed_1", bus.o_speed_level, 32'd1);
        @(negedge clk);
        check("milestone_one_cycle", bus.o_milestone_pulse, 32'd0);

        ticks(69);
        check("score_123", bus.o_score, 32'h0123);
        #2 rst = 1'b1;
        #1;
        check("async_rst_score", bus.o_score, 32'h0000);
        check("async_rst_running", bus.o_running, 32'd0);
        check("async_rst_speed", bus.o_speed_level, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ticks(9);
        check("post_rst_no_count", bus.o_score, 32'h0000);

        pulse(1'b1, 1'b0, 1'b0);
        ticks(128);
        check("score_42", bus.o_score, 32'h0042);
        pulse(1'b0, 1'b1, 1'b1);
        check("over_tick_score", bus.o_score, 32'h0042);
        check("over_tick_high", bus.o_high_score, 32'h0042);
        check("over_tick_running", bus.o_running, 32'd0);
        ticks(3);
        check("over_ticks_hold", bus.o_score, 32'h0042);
        pulse(1'b0, 1'b1, 1'b0);
        check("over_in_over", bus.o_running, 32'd0);

        pulse(1'b1, 1'b0, 1'b0);
        check("game2_score", bus.o_score, 32'h0000);
        check("game2_running", bus.o_running, 32'd1);
        check("game2_high_kept", bus.o_high_score, 32'h0042);
        ticks(30);
        check("game2_score_10", bus.o_score, 32'h0010);
        pulse(1'b1, 1'b0, 1'b0);
        check("start_in_running", bus.o_score, 32'h0010);
        check("start_in_running_run", bus.o_running, 32'd1);
        pulse(1'b1, 1'b1, 1'b0);
        check("start_over_running", bus.o_running, 32'd0);
        check("game2_high", bus.o_high_score, 32'h0042);

        pulse(1'b1, 1'b0, 1'b0);
        check("game3_score", bus.o_score, 32'h0000);
        ticks(29697);
        check("score_9899", bus.o_score, 32'h9899);
        check("speed_saturated", bus.o_speed_level, 32'd7);
        ticks(3);
        check("score_9900", bus.o_score, 32'h9900);
        check("milestone_at_7", bus.o_milestone_pulse, 32'd1);
        check("speed_stays_7", bus.o_speed_level, 32'd7);
        ticks(294);
        check("score_9998", bus.o_score, 32'h9998);
        ticks(18);
        check("score_saturate", bus.o_score, 32'h9999);
        check("no_milestone_sat", bus.o_milestone_pulse, 32'd0);
        pulse(1'b0, 1'b1, 1'b0);
        check("high_9999", bus.o_high_score, 32'h9999);
        check("final_score", bus.o_score, 32'h9999);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
